// File: rtl/aes_inv_key_sched.sv
// AES-128 round-key generator for decryption: expands forward to K10 once,
// then walks the schedule backward one round per consumer request.
module aes_inv_key_sched #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         key_req,
    output logic         busy,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned RC_W   = 8;

    typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xtime(aa);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [RND_W-1:0]  cnt_q, cnt_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] w0, w1, w2, w3, w3_back;
    logic [WORD_W-1:0] sbox_in, sbox_out, rc_word;
    logic [WORD_W-1:0] f0, f1, f2, f3;
    logic [KEY_W-1:0]  key_fwd, key_bwd;
    logic [RC_W-1:0]   rc_inv;

    assign w0      = key_q[127:96];
    assign w1      = key_q[95:64];
    assign w2      = key_q[63:32];
    assign w3      = key_q[31:0];
    assign w3_back = w3 ^ w2;
    assign rc_word = {rc_q, 24'h000000};

    // One shared S-box: forward uses w3, backward needs the recovered w3
    assign sbox_in  = (state_q == SERVE) ? rot_word(w3_back) : rot_word(w3);
    assign sbox_out = sub_word(sbox_in);

    assign f0      = w0 ^ sbox_out ^ rc_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign key_fwd = {f0, f1, f2, f3};
    assign key_bwd = {w0 ^ sbox_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3_back};
    assign rc_inv  = rc_q[0] ? (((rc_q ^ 8'h1b) >> 1) | 8'h80) : (rc_q >> 1);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d   = key_in;
                    cnt_d   = '0;
                    rc_d    = 8'h01;
                    round_d = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                key_d = key_fwd;
                if (cnt_q == RND_W'(NUM_ROUNDS - 1)) begin
                    round_d = RND_W'(NUM_ROUNDS);
                    state_d = SERVE;
                end else begin
                    cnt_d = cnt_q + RND_W'(1);
                    rc_d  = xtime(rc_q);
                end
            end
            SERVE: begin
                if (key_load) begin
                    key_d   = key_in;
                    cnt_d   = '0;
                    rc_d    = 8'h01;
                    round_d = '0;
                    state_d = EXPAND;
                end else if (key_req) begin
                    if (round_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = key_bwd;
                        rc_d    = rc_inv;
                        round_d = round_q - RND_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // round_q is cleared on every load, so it already reads 0 outside SERVE
    assign busy      = (state_q == EXPAND);
    assign key_valid = (state_q == SERVE);
    assign key_out   = (state_q == SERVE) ? key_q : '0;
    assign key_round = round_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a FIPS-197 table-driven
// key-expansion model.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_req;
    logic         busy;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         done;

    aes_inv_key_sched dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .key_req(key_req), .busy(busy), .key_valid(key_valid),
        .key_out(key_out), .key_round(key_round), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [127:0] rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Textbook 44-word expansion; fills rk[0..10]
    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]}
                    ^ {RCON[i/4 - 1], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; key_load = 1'b0; key_req = 1'b0; key_in = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({busy, key_valid, key_out, key_round, done} !== 135'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {busy, key_valid, key_out, key_round, done});
        end
        key_req = 1'b1;
        tick();
        key_req = 1'b0;
        total++;
        if ({busy, key_valid, key_out, key_round, done} !== 135'd0) begin
            bad++; $display("FAIL idle_req_ignored got=%h exp=0", {busy, key_valid, key_out, key_round, done});
        end
    endtask

    task automatic test_load_walk();
        model(FIPS_KEY);
        load(FIPS_KEY);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({busy, key_valid, key_round, done} !== 7'b1000000 || key_out !== '0) begin
                bad++; $display("FAIL expand_flags cyc=%0d got=%b exp=1000000", i, {busy, key_valid, key_round, done});
            end
            tick();
        end
        total++;
        if (key_out !== FIPS_K10) begin
            bad++; $display("FAIL fips_k10 got=%h exp=%h", key_out, FIPS_K10);
        end
        key_req = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            total++;
            if (key_valid !== 1'b1 || busy !== 1'b0 || key_round !== 4'(r) || key_out !== rk[r]) begin
                bad++; $display("FAIL walk r=%0d got=%0d/%h exp=%0d/%h", r, key_round, key_out, r, rk[r]);
            end
            if (r == 9) begin
                total++;
                if (key_out !== FIPS_K9) begin bad++; $display("FAIL fips_k9 got=%h exp=%h", key_out, FIPS_K9); end
            end
            if (r == 1) begin
                total++;
                if (key_out !== FIPS_K1) begin bad++; $display("FAIL fips_k1 got=%h exp=%h", key_out, FIPS_K1); end
            end
            if (r == 0) begin
                total++;
                if (key_out !== FIPS_KEY) begin bad++; $display("FAIL fips_k0 got=%h exp=%h", key_out, FIPS_KEY); end
            end
            tick();
        end
        key_req = 1'b0;
        total++;
        if ({key_valid, done, key_round} !== 6'b010000 || key_out !== '0) begin
            bad++; $display("FAIL done_pulse got=%b exp=010000", {key_valid, done, key_round});
        end
        tick();
        total++;
        if ({busy, key_valid, done} !== 3'b000) begin
            bad++; $display("FAIL done_clear got=%b exp=000", {busy, key_valid, done});
        end
    endtask

    task automatic test_stalled();
        for (int n = 0; n < 2; n++) begin
            logic [127:0] k;
            int exp_r;
            bit finished;
            k = (n == 0) ? FIPS_KEY : rand_key();
            model(k);
            load(k);
            repeat (10) tick();
            exp_r = 10;
            finished = 1'b0;
            for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
                bit req;
                total++;
                if (key_valid !== 1'b1 || done !== 1'b0 || key_round !== 4'(exp_r) || key_out !== rk[exp_r]) begin
                    bad++; $display("FAIL stall cyc=%0d got=%0d/%h exp=%0d/%h", cyc, key_round, key_out, exp_r, rk[exp_r]);
                end
                req = 1'($urandom_range(0, 1));
                key_req = req;
                tick();
                if (req) begin
                    if (exp_r == 0) finished = 1'b1;
                    else exp_r--;
                end
            end
            key_req = 1'b0;
            total++;
            if (!finished || done !== 1'b1 || key_valid !== 1'b0) begin
                bad++; $display("FAIL stall_done got=%b%b exp=10 finished=%0b", done, key_valid, finished);
            end
            tick();
        end
    endtask

    task automatic test_reload();
        load(FIPS_KEY);
        repeat (10) tick();
        key_req = 1'b1;
        repeat (5) tick();
        total++;
        if (key_round !== 4'd5) begin bad++; $display("FAIL reload_at5 got=%0d exp=5", key_round); end
        key_in = SEQ_KEY; key_load = 1'b1;
        tick();
        key_load = 1'b0; key_req = 1'b0;
        model(SEQ_KEY);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({busy, key_valid, done} !== 3'b100) begin
                bad++; $display("FAIL reload_expand cyc=%0d got=%b exp=100", i, {busy, key_valid, done});
            end
            tick();
        end
        total++;
        if (key_valid !== 1'b1 || key_round !== 4'd10 || key_out !== SEQ_K10 || key_out !== rk[10]) begin
            bad++; $display("FAIL reload_k10 got=%0d/%h exp=10/%h", key_round, key_out, SEQ_K10);
        end
        key_req = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            total++;
            if (key_round !== 4'(r) || key_out !== rk[r] || done !== 1'b0) begin
                bad++; $display("FAIL reload_walk r=%0d got=%0d/%h exp=%0d/%h", r, key_round, key_out, r, rk[r]);
            end
            tick();
        end
        key_req = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL reload_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_ignored();
        logic [127:0] k;
        k = rand_key();
        model(k);
        load(k);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({busy, key_valid} !== 2'b10) begin
                bad++; $display("FAIL ignored_busy cyc=%0d got=%b exp=10", i, {busy, key_valid});
            end
            key_load = (i == 2);
            key_in   = rand_key();
            key_req  = (i == 5 || i == 9);
            tick();
            key_load = 1'b0; key_req = 1'b0;
        end
        total++;
        if (key_valid !== 1'b1 || key_round !== 4'd10 || key_out !== rk[10]) begin
            bad++; $display("FAIL ignored_k10 got=%0d/%h exp=10/%h", key_round, key_out, rk[10]);
        end
        key_req = 1'b1;
        repeat (11) tick();
        key_req = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL ignored_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        load(FIPS_KEY);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, key_valid, key_out, key_round, done} !== 135'd0) begin
            bad++; $display("FAIL rst_expand got=%h exp=0", {busy, key_valid, key_out, key_round, done});
        end
        tick();
        total++;
        if ({busy, key_valid, done} !== 3'b000) begin
            bad++; $display("FAIL rst_expand_idle got=%b exp=000", {busy, key_valid, done});
        end
        load(FIPS_KEY);
        repeat (10) tick();
        key_req = 1'b1;
        repeat (3) tick();
        key_req = 1'b0;
        total++;
        if (key_round !== 4'd7) begin bad++; $display("FAIL rst_serve_at7 got=%0d exp=7", key_round); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, key_valid, key_out, key_round, done} !== 135'd0) begin
            bad++; $display("FAIL rst_serve got=%h exp=0", {busy, key_valid, key_out, key_round, done});
        end
        model(FIPS_KEY);
        load(FIPS_KEY);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({busy, key_valid} !== 2'b10) begin
                bad++; $display("FAIL rst_reload_busy cyc=%0d got=%b exp=10", i, {busy, key_valid});
            end
            tick();
        end
        total++;
        if (key_valid !== 1'b1 || key_round !== 4'd10 || key_out !== FIPS_K10) begin
            bad++; $display("FAIL rst_reload_k10 got=%0d/%h exp=10/%h", key_round, key_out, FIPS_K10);
        end
        key_req = 1'b1;
        repeat (11) tick();
        key_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            logic [127:0] k;
            k = rand_key();
            model(k);
            load(k);
            repeat (10) tick();
            key_req = 1'b1;
            for (int r = 10; r >= 0; r--) begin
                total++;
                if (key_valid !== 1'b1 || key_round !== 4'(r) || key_out !== rk[r]) begin
                    bad++; $display("FAIL b2b n=%0d r=%0d got=%0d/%h exp=%h", n, r, key_round, key_out, rk[r]);
                end
                tick();
            end
            key_req = 1'b0;
            total++;
            if ({done, key_valid} !== 2'b10) begin
                bad++; $display("FAIL b2b_done n=%0d got=%b exp=10", n, {done, key_valid});
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_walk();
        test_stalled();
        test_reload();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
